// File: rtl/sgm_frame_controller_if.sv
// Video-in / control-out bundle for sgm_frame_controller.
// frame_cnt / err_cnt exist only when SGM_CTRL_STATS_EN is defined.
interface sgm_frame_controller_if #(
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 720
);
  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic             de_in;
  logic             h_sync_in;
  logic             v_sync_in;
  logic [COL_W-1:0] col_idx;
  logic [ROW_W-1:0] row_idx;
  logic             ctrl_valid;
  logic             path_rst_h;
  logic             path_rst_v;
  logic             disp_valid;
  logic             de_out;
  logic             h_sync_out;
  logic             v_sync_out;
  logic             frame_err;
`ifdef SGM_CTRL_STATS_EN
  logic [15:0]      frame_cnt;
  logic [7:0]       err_cnt;

  modport master (
    output de_in, h_sync_in, v_sync_in,
    input  col_idx, row_idx, ctrl_valid, path_rst_h, path_rst_v, disp_valid,
    input  de_out, h_sync_out, v_sync_out, frame_err, frame_cnt, err_cnt
  );
  modport slave (
    input  de_in, h_sync_in, v_sync_in,
    output col_idx, row_idx, ctrl_valid, path_rst_h, path_rst_v, disp_valid,
    output de_out, h_sync_out, v_sync_out, frame_err, frame_cnt, err_cnt
  );
`else
  modport master (
    output de_in, h_sync_in, v_sync_in,
    input  col_idx, row_idx, ctrl_valid, path_rst_h, path_rst_v, disp_valid,
    input  de_out, h_sync_out, v_sync_out, frame_err
  );
  modport slave (
    input  de_in, h_sync_in, v_sync_in,
    output col_idx, row_idx, ctrl_valid, path_rst_h, path_rst_v, disp_valid,
    output de_out, h_sync_out, v_sync_out, frame_err
  );
`endif
endinterface

// File: rtl/sgm_frame_controller.sv
// SGM frame sequencer: pixel position tracking, path-cost resets, disparity mask, sync delay, framing errors.
// Optional statistics counters (frame_cnt, err_cnt) enabled by defining SGM_CTRL_STATS_EN.
module sgm_frame_controller #(
  parameter int IMG_WIDTH       = 1280,
  parameter int IMG_HEIGHT      = 720,
  parameter int DISPARITY_RANGE = 8,
  parameter int PIPE_LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sgm_frame_controller_if.slave vid
);
  localparam int COL_W      = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W      = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int ROW_CNT_W  = $clog2(IMG_HEIGHT + 1);
  localparam int DISP_FIRST = DISPARITY_RANGE - 1;

  localparam logic [COL_W-1:0]     COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_CNT_W-1:0] ROW_LIMIT = ROW_CNT_W'(IMG_HEIGHT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LINE,
    ACTIVE,
    BLANK
  } state_t;

  state_t               state;
  logic [COL_W-1:0]     col_cnt;
  logic [ROW_CNT_W-1:0] row_cnt;
  logic                 vs_q;

  logic [COL_W-1:0]     col_idx_q;
  logic [ROW_W-1:0]     row_idx_q;
  logic                 ctrl_valid_q;
  logic                 path_rst_h_q;
  logic                 path_rst_v_q;
  logic                 disp_valid_q;
  logic                 frame_err_q;

  logic                 vs_rise;
  logic                 accept;
  logic                 line_err;
  logic [COL_W-1:0]     pix_col;

  assign vs_rise = vid.v_sync_in & ~vs_q;

  // Decide whether this clock's de_in is a pixel, an error, or ignored; row_cnt equals ROW_LIMIT only
  // after the last allowed line has closed, so a new line then means too many lines.
  always_comb begin
    accept   = 1'b0;
    line_err = 1'b0;
    pix_col  = '0;
    if (!vs_rise && vid.de_in) begin
      case (state)
        ACTIVE: begin
          if (col_cnt == COL_LAST) begin
            line_err = 1'b1;
          end else begin
            accept  = 1'b1;
            pix_col = col_cnt + 1'b1;
          end
        end
        WAIT_LINE, BLANK: begin
          if (row_cnt == ROW_LIMIT) begin
            line_err = 1'b1;
          end else begin
            accept = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      col_cnt      <= '0;
      row_cnt      <= '0;
      vs_q         <= 1'b0;
      col_idx_q    <= '0;
      row_idx_q    <= '0;
      ctrl_valid_q <= 1'b0;
      path_rst_h_q <= 1'b0;
      path_rst_v_q <= 1'b0;
      disp_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      vs_q         <= vid.v_sync_in;
      ctrl_valid_q <= accept;
      frame_err_q  <= line_err;
      path_rst_h_q <= accept && (pix_col == '0);
      path_rst_v_q <= accept && (row_cnt == '0);
      disp_valid_q <= accept && (int'(pix_col) >= DISP_FIRST);
      if (accept) begin
        col_idx_q <= pix_col;
        row_idx_q <= row_cnt[ROW_W-1:0];
      end

      if (vs_rise) begin
        state   <= WAIT_LINE;
        col_cnt <= '0;
        row_cnt <= '0;
      end else begin
        case (state)
          WAIT_LINE, BLANK: begin
            if (vid.de_in) begin
              if (line_err) begin
                state <= IDLE;
              end else begin
                state   <= ACTIVE;
                col_cnt <= '0;
              end
            end
          end
          ACTIVE: begin
            if (!vid.de_in) begin
              state   <= BLANK;
              col_cnt <= '0;
              if (row_cnt != ROW_LIMIT) begin
                row_cnt <= row_cnt + 1'b1;
              end
            end else if (line_err) begin
              state <= IDLE;
            end else begin
              col_cnt <= pix_col;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign vid.col_idx    = col_idx_q;
  assign vid.row_idx    = row_idx_q;
  assign vid.ctrl_valid = ctrl_valid_q;
  assign vid.path_rst_h = path_rst_h_q;
  assign vid.path_rst_v = path_rst_v_q;
  assign vid.disp_valid = disp_valid_q;
  assign vid.frame_err  = frame_err_q;

  // Sync delay line is free-running so downstream timing never depends on framing state.
  logic [2:0] sync_pipe [PIPE_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        sync_pipe[i] <= 3'b000;
      end
    end else begin
      sync_pipe[0] <= {vid.de_in, vid.h_sync_in, vid.v_sync_in};
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        sync_pipe[i] <= sync_pipe[i-1];
      end
    end
  end

  assign vid.de_out     = sync_pipe[PIPE_LATENCY-1][2];
  assign vid.h_sync_out = sync_pipe[PIPE_LATENCY-1][1];
  assign vid.v_sync_out = sync_pipe[PIPE_LATENCY-1][0];

`ifdef SGM_CTRL_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;
  logic        frame_has_pix;

  // A frame only counts once it has delivered at least one pixel, so back-to-back vsyncs are not frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
      frame_has_pix <= 1'b0;
    end else begin
      if (vs_rise) begin
        frame_has_pix <= 1'b0;
        if (frame_has_pix) begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end else if (accept) begin
        frame_has_pix <= 1'b1;
      end
      if (line_err && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign vid.frame_cnt = frame_cnt_q;
  assign vid.err_cnt   = err_cnt_q;
`endif
endmodule

// File: tb/tb_sgm_frame_controller.sv
// Randomized and directed bench for sgm_frame_controller against a line/pixel-count reference model.
// Statistics outputs are also checked when SGM_CTRL_STATS_EN is defined.
module tb_sgm_frame_controller;
  localparam int W  = 16;
  localparam int H  = 4;
  localparam int DR = 8;
  localparam int PL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sgm_frame_controller_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) vid ();

  sgm_frame_controller #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .DISPARITY_RANGE(DR), .PIPE_LATENCY(PL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vid(vid)
  );

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: a frame is a count of completed lines plus pixels seen in the open line.
  bit       armed, vsPrev, frameHasPix;
  int       linesDone, pixInLine, expFrames, expErrs;
  bit [2:0] hist[$];
  bit       expValid, expErr;
  int       expCol, expRow;
  int       obsValid, obsRstH, obsRstV, obsDisp, obsErr;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic resetModel();
    armed = 0; vsPrev = 0; frameHasPix = 0;
    linesDone = 0; pixInLine = 0; expFrames = 0; expErrs = 0;
    expValid = 0; expErr = 0; expCol = 0; expRow = 0;
    hist.delete();
    for (int i = 0; i < PL - 1; i++) hist.push_back(3'b000);
  endtask

  task automatic clearObs();
    obsValid = 0; obsRstH = 0; obsRstV = 0; obsDisp = 0; obsErr = 0;
  endtask

  task automatic sampleOutputs();
    bit [2:0] dly;
    dly = hist.pop_front();
    checkOutput("ctrl_valid", 32'(vid.ctrl_valid), 32'(expValid));
    checkOutput("frame_err", 32'(vid.frame_err), 32'(expErr));
    checkOutput("path_rst_h", 32'(vid.path_rst_h), 32'(expValid && expCol == 0));
    checkOutput("path_rst_v", 32'(vid.path_rst_v), 32'(expValid && expRow == 0));
    checkOutput("disp_valid", 32'(vid.disp_valid), 32'(expValid && expCol >= DR - 1));
    if (expValid) begin
      checkOutput("col_idx", 32'(vid.col_idx), 32'(expCol));
      checkOutput("row_idx", 32'(vid.row_idx), 32'(expRow));
    end
    checkOutput("de_out", 32'(vid.de_out), 32'(dly[2]));
    checkOutput("h_sync_out", 32'(vid.h_sync_out), 32'(dly[1]));
    checkOutput("v_sync_out", 32'(vid.v_sync_out), 32'(dly[0]));
`ifdef SGM_CTRL_STATS_EN
    checkOutput("frame_cnt", 32'(vid.frame_cnt), 32'(expFrames));
    checkOutput("err_cnt", 32'(vid.err_cnt), 32'(expErrs));
`endif
    obsValid += int'(vid.ctrl_valid);
    obsRstH  += int'(vid.path_rst_h);
    obsRstV  += int'(vid.path_rst_v);
    obsDisp  += int'(vid.disp_valid);
    obsErr   += int'(vid.frame_err);
  endtask

  // One clock of stimulus: drive inputs, advance the model, then compare after the edge.
  task automatic applyStimulus(input bit de, input bit hs, input bit vs);
    bit vsRise;
    vid.de_in = de; vid.h_sync_in = hs; vid.v_sync_in = vs;
    vsRise = vs && !vsPrev;
    vsPrev = vs;
    expValid = 0; expErr = 0;
    if (vsRise) begin
      if (frameHasPix) expFrames++;
      frameHasPix = 0;
      armed = 1; linesDone = 0; pixInLine = 0;
    end else if (armed && de) begin
      if ((pixInLine == 0 && linesDone == H) || pixInLine == W) begin
        expErr = 1; armed = 0;
        if (expErrs < 255) expErrs++;
      end else begin
        expValid = 1; expCol = pixInLine; expRow = linesDone;
        pixInLine++; frameHasPix = 1;
      end
    end else if (armed && !de && pixInLine > 0) begin
      linesDone++; pixInLine = 0;
    end
    hist.push_back({de, hs, vs});
    @(posedge clk);
    #1;
    sampleOutputs();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    vid.de_in = 0; vid.h_sync_in = 0; vid.v_sync_in = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst ctrl_valid", 32'(vid.ctrl_valid), 32'd0);
    checkOutput("rst col_idx", 32'(vid.col_idx), 32'd0);
    checkOutput("rst row_idx", 32'(vid.row_idx), 32'd0);
    checkOutput("rst frame_err", 32'(vid.frame_err), 32'd0);
    checkOutput("rst de_out", 32'(vid.de_out), 32'd0);
    checkOutput("rst v_sync_out", 32'(vid.v_sync_out), 32'd0);
    rst_n = 1'b1;
    resetModel();
  endtask

  task automatic vsyncPulse();
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
  endtask

  task automatic sendLine(input int len, input int blank);
    for (int i = 0; i < len; i++) applyStimulus(1, 0, 0);
    for (int i = 0; i < blank; i++) applyStimulus(0, 1, 0);
  endtask

  initial begin
    resetModel();
    clearObs();

    // Full frame of 4 x 16 pixels
    doReset();
    vsyncPulse();
    clearObs();
    for (int l = 0; l < H; l++) sendLine(W, 3);
    checkOutput("t1 valid count", 32'(obsValid), 32'd64);
    checkOutput("t1 rst_v count", 32'(obsRstV), 32'd16);
    checkOutput("t1 rst_h count", 32'(obsRstH), 32'd4);
    checkOutput("t1 disp count", 32'(obsDisp), 32'd36);
    checkOutput("t1 err count", 32'(obsErr), 32'd0);
    vsyncPulse();
`ifdef SGM_CTRL_STATS_EN
    checkOutput("t1 frame_cnt", 32'(vid.frame_cnt), 32'd1);
`endif

    // de before any vsync is ignored
    doReset();
    clearObs();
    for (int i = 0; i < 6; i++) applyStimulus(i[0] == 1'b0, 0, 0);
    checkOutput("t2 no valid", 32'(obsValid), 32'd0);
    vsyncPulse();
    sendLine(W, 2);

    // Line too long
    vsyncPulse();
    clearObs();
    sendLine(W + 1, 3);
    checkOutput("t3 err count", 32'(obsErr), 32'd1);
    checkOutput("t3 valid count", 32'(obsValid), 32'd16);
`ifdef SGM_CTRL_STATS_EN
    checkOutput("t3 err_cnt", 32'(vid.err_cnt), 32'd1);
`endif
    clearObs();
    sendLine(W, 2);
    checkOutput("t3 idle after err", 32'(obsValid), 32'd0);

    // Too many lines, then recovery on the next frame
    vsyncPulse();
    clearObs();
    for (int l = 0; l < H + 1; l++) sendLine(W, 2);
    checkOutput("t4 err count", 32'(obsErr), 32'd1);
    vsyncPulse();
    clearObs();
    sendLine(W, 2);
    checkOutput("t4 rst_v count", 32'(obsRstV), 32'd16);

    // Random toggling of all three inputs
    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Random frames with occasional over-long lines and over-tall frames
    for (int f = 0; f < 20; f++) begin
      int nLines;
      vsyncPulse();
      nLines = $urandom_range(1, H + 1);
      for (int l = 0; l < nLines; l++) begin
        int len;
        len = ($urandom_range(0, 4) == 0) ? W + 1 : $urandom_range(1, W);
        sendLine(len, $urandom_range(1, 4));
      end
    end

    // Asynchronous reset in the middle of a line
    doReset();
    vsyncPulse();
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0);
    checkOutput("t6 pre col", 32'(vid.col_idx), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6 async valid", 32'(vid.ctrl_valid), 32'd0);
    checkOutput("t6 async col", 32'(vid.col_idx), 32'd0);
    checkOutput("t6 async de_out", 32'(vid.de_out), 32'd0);
    doReset();
    clearObs();
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);
    checkOutput("t6 no valid", 32'(obsValid), 32'd0);
    vsyncPulse();
    sendLine(W, 2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
